// File: rtl/mem_stage_ls.sv
// mem_stage_ls: memory-access stage with registered MEM/WB outputs.
// Loads/stores run a req/ack bus access and stall upstream until done.
module mem_stage_ls #(
   parameter int REG_ADDR_W  = 5,
   parameter int DATA_W      = 32,
   parameter bit BIG_ENDIAN  = 1'b1,
   parameter int BUS_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [3:0]            mem_op_i,
   input  logic [DATA_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_sdata_i,
   output logic                  stall_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [DATA_W-1:0]     bus_addr_o,
   output logic [DATA_W/8-1:0]   bus_sel_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_ack_i,
   output logic                  wb_valid_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic                  align_err_o,
   output logic                  bus_err_o
);

   localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_N = 2'd3;

   logic [0:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic                  done_q;
   logic [3:0]            op_q;
   logic [DATA_W-1:0]     addr_q;
   logic [DATA_W-1:0]     sdata_q;
   logic [REG_ADDR_W-1:0] wd_q;
   logic                  wreg_q;

   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd6: op_size = SZ_B;
         4'd3, 4'd4, 4'd7: op_size = SZ_H;
         4'd5, 4'd8:       op_size = SZ_W;
         default:          op_size = SZ_N;
      endcase
   endfunction

   logic [1:0] sz_i;
   logic       misal;
   logic       accept;
   logic       busy;
   logic       ld_q;
   logic       to_hit;

   assign sz_i  = op_size(mem_op_i);
   assign misal = ((sz_i == SZ_H) && mem_addr_i[0])
               || ((sz_i == SZ_W) && (mem_addr_i[1:0] != 2'b00));
   assign busy  = (state == BUSY);

   // A completed access leaves its instruction held for one more cycle.
   assign accept = (state == IDLE) && !done_q && valid_i
                && (sz_i != SZ_N) && !misal;

   assign ld_q   = (op_q >= 4'd1) && (op_q <= 4'd5);
   assign to_hit = (cnt == CNT_W'(BUS_TIMEOUT - 1));

   assign stall_o   = busy | accept;
   assign bus_req_o = busy;

   logic [1:0]        sz_q;
   logic [1:0]        a_q;
   logic [1:0]        bi;
   logic              hi;
   logic [3:0]        sel;
   logic [DATA_W-1:0] st_data;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [DATA_W-1:0] ld_data;

   assign sz_q = op_size(op_q);
   assign a_q  = addr_q[1:0];
   assign bi   = BIG_ENDIAN ? ~a_q : a_q;
   assign hi   = a_q[1] ^ BIG_ENDIAN;
   assign ld_b = bus_rdata_i[{bi, 3'b000} +: 8];
   assign ld_h = bus_rdata_i[{hi, 4'b0000} +: 16];

   always_comb begin
      sel     = 4'b0000;
      st_data = sdata_q;
      case (sz_q)
         SZ_B: begin
            sel     = BIG_ENDIAN ? (4'b1000 >> a_q) : (4'b0001 << a_q);
            st_data = {4{sdata_q[7:0]}};
         end
         SZ_H: begin
            sel     = hi ? 4'b1100 : 4'b0011;
            st_data = {2{sdata_q[15:0]}};
         end
         SZ_W: sel = 4'b1111;
         default: sel = 4'b0000;
      endcase
   end

   always_comb begin
      ld_data = bus_rdata_i;
      case (op_q)
         4'd1: ld_data = {{24{ld_b[7]}}, ld_b};
         4'd2: ld_data = {24'b0, ld_b};
         4'd3: ld_data = {{16{ld_h[15]}}, ld_h};
         4'd4: ld_data = {16'b0, ld_h};
         default: ld_data = bus_rdata_i;
      endcase
   end

   assign bus_we_o    = busy && (op_q >= 4'd6) && (op_q <= 4'd8);
   assign bus_addr_o  = {addr_q[DATA_W-1:2], 2'b00};
   assign bus_sel_o   = busy ? sel : 4'b0000;
   assign bus_wdata_o = st_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         done_q      <= 1'b0;
         op_q        <= '0;
         addr_q      <= '0;
         sdata_q     <= '0;
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         wb_valid_o  <= 1'b0;
         wd_o        <= '0;
         wreg_o      <= 1'b0;
         wdata_o     <= '0;
         align_err_o <= 1'b0;
         bus_err_o   <= 1'b0;
      end else begin
         align_err_o <= 1'b0;
         bus_err_o   <= 1'b0;
         wb_valid_o  <= 1'b0;
         wd_o        <= '0;
         wreg_o      <= 1'b0;
         wdata_o     <= '0;
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (done_q || !valid_i) begin
                  wb_valid_o <= 1'b0;
               end else if (sz_i == SZ_N) begin
                  wb_valid_o <= 1'b1;
                  wd_o       <= wd_i;
                  wreg_o     <= wreg_i;
                  wdata_o    <= wdata_i;
               end else if (misal) begin
                  wb_valid_o  <= 1'b1;
                  wd_o        <= wd_i;
                  align_err_o <= 1'b1;
               end else begin
                  state   <= BUSY;
                  cnt     <= '0;
                  op_q    <= mem_op_i;
                  addr_q  <= mem_addr_i;
                  sdata_q <= mem_sdata_i;
                  wd_q    <= wd_i;
                  wreg_q  <= wreg_i;
               end
            end
            BUSY: begin
               if (bus_ack_i) begin
                  state      <= IDLE;
                  done_q     <= 1'b1;
                  wb_valid_o <= 1'b1;
                  wd_o       <= wd_q;
                  wreg_o     <= ld_q & wreg_q;
                  wdata_o    <= ld_q ? ld_data : '0;
               end else if (to_hit) begin
                  state      <= IDLE;
                  done_q     <= 1'b1;
                  cnt        <= '0;
                  wb_valid_o <= 1'b1;
                  wd_o       <= wd_q;
                  bus_err_o  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: directed vectors for mem_stage_ls (BUS_TIMEOUT=4).
module tb_mem_stage_ls;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_sdata_i;
   logic        stall_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        wb_valid_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        align_err_o;
   logic        bus_err_o;

   mem_stage_ls #(.BUS_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i),
      .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
      .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
      .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
      .bus_ack_i(bus_ack_i), .wb_valid_o(wb_valid_o), .wd_o(wd_o),
      .wreg_o(wreg_o), .wdata_o(wdata_o), .align_err_o(align_err_o),
      .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int          stall_n, req_n;
   logic [3:0]  sel_s;
   logic        we_s;
   logic [31:0] addr_s, bwd_s;
   logic        c_wbv, c_wreg, c_berr, c_wbv2, c_berr2;
   logic [4:0]  c_wd;
   logic [31:0] c_wdata;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ack_at: BUSY cycle (1-based) carrying the ack; 0 never acks
   task automatic mem_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata,
                             input int ack_at);
      int n;
      valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr;
      mem_sdata_i = sdata; bus_rdata_i = rdata;
      wd_i = 5'd7; wreg_i = 1'b1;
      stall_n = 0; req_n = 0; n = 0;
      sel_s = '0; we_s = 1'b0; addr_s = '0; bwd_s = '0;
      #1;
      while (stall_o && n < 20) begin
         stall_n++;
         if (bus_req_o) begin
            req_n++;
            sel_s = bus_sel_o; we_s = bus_we_o;
            addr_s = bus_addr_o; bwd_s = bus_wdata_o;
         end
         bus_ack_i = bus_req_o && (req_n == ack_at);
         step();
         bus_ack_i = 1'b0;
         n++;
      end
      check("stall_release", {31'b0, stall_o}, 32'd0);
      c_wbv = wb_valid_o; c_wreg = wreg_o; c_wd = wd_o;
      c_wdata = wdata_o; c_berr = bus_err_o;
      valid_i = 1'b0;
      step();
      c_wbv2 = wb_valid_o; c_berr2 = bus_err_o;
   endtask

   initial begin
      rst = 1'b1; valid_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
      mem_op_i = 0; mem_addr_i = 0; mem_sdata_i = 0;
      bus_rdata_i = 0; bus_ack_i = 0;
      step(); step();
      check("rst_wbv", {31'b0, wb_valid_o}, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_wd", {27'b0, wd_o}, 0);
      check("rst_req", {31'b0, bus_req_o}, 0);
      check("rst_stall", {31'b0, stall_o}, 0);
      check("rst_errs", {30'b0, align_err_o, bus_err_o}, 0);
      rst = 1'b0;

      valid_i = 1; mem_op_i = 0; wd_i = 3; wreg_i = 1; wdata_i = 32'h1234;
      #1 check("add_stall", {31'b0, stall_o}, 0);
      step();
      check("add_wbv", {31'b0, wb_valid_o}, 1);
      check("add_wd", {27'b0, wd_o}, 3);
      check("add_wreg", {31'b0, wreg_o}, 1);
      check("add_wdata", wdata_o, 32'h1234);
      valid_i = 0;
      step();
      check("idle_wbv", {31'b0, wb_valid_o}, 0);
      check("idle_wreg", {31'b0, wreg_o}, 0);

      mem_access(4'd1, 32'h101, 0, 32'h118A3344, 2);
      check("lb_stall_n", stall_n, 3);
      check("lb_sel", {28'b0, sel_s}, 32'h4);
      check("lb_we", {31'b0, we_s}, 0);
      check("lb_wbv", {31'b0, c_wbv}, 1);
      check("lb_wreg", {31'b0, c_wreg}, 1);
      check("lb_wd", {27'b0, c_wd}, 7);
      check("lb_wdata", c_wdata, 32'hFFFFFF8A);
      check("lb_bubble", {31'b0, c_wbv2}, 0);
      mem_access(4'd2, 32'h101, 0, 32'h118A3344, 2);
      check("lbu_wdata", c_wdata, 32'h0000008A);
      mem_access(4'd3, 32'h100, 0, 32'h80011234, 1);
      check("lh_stall_n", stall_n, 2);
      check("lh_sel", {28'b0, sel_s}, 32'hC);
      check("lh_wdata", c_wdata, 32'hFFFF8001);
      mem_access(4'd4, 32'h102, 0, 32'h80019234, 1);
      check("lhu_wdata", c_wdata, 32'h00009234);
      mem_access(4'd5, 32'h104, 0, 32'hDEADBEEF, 1);
      check("lw_sel", {28'b0, sel_s}, 32'hF);
      check("lw_wdata", c_wdata, 32'hDEADBEEF);

      mem_access(4'd7, 32'h202, 32'h0000BEEF, 0, 1);
      check("sh_we", {31'b0, we_s}, 1);
      check("sh_sel", {28'b0, sel_s}, 32'h3);
      check("sh_bwdata", bwd_s, 32'hBEEFBEEF);
      check("sh_addr", addr_s, 32'h200);
      check("sh_wbv", {31'b0, c_wbv}, 1);
      check("sh_wreg", {31'b0, c_wreg}, 0);
      mem_access(4'd6, 32'h203, 32'h1234565A, 0, 1);
      check("sb_sel", {28'b0, sel_s}, 32'h1);
      check("sb_bwdata", bwd_s, 32'h5A5A5A5A);

      valid_i = 1; mem_op_i = 4'd5; mem_addr_i = 32'h103; wd_i = 4; wreg_i = 1;
      #1 check("mis_stall", {31'b0, stall_o}, 0);
      step();
      check("mis_req", {31'b0, bus_req_o}, 0);
      check("mis_wbv", {31'b0, wb_valid_o}, 1);
      check("mis_wreg", {31'b0, wreg_o}, 0);
      check("mis_align", {31'b0, align_err_o}, 1);
      mem_op_i = 4'd3; mem_addr_i = 32'h101;
      step();
      check("mish_align", {31'b0, align_err_o}, 1);
      valid_i = 0;
      step();
      check("mis_pulse", {31'b0, align_err_o}, 0);

      mem_access(4'd8, 32'h300, 32'hCAFEF00D, 0, 0);
      check("to_req_n", req_n, 4);
      check("to_berr", {31'b0, c_berr}, 1);
      check("to_wbv", {31'b0, c_wbv}, 1);
      check("to_wreg", {31'b0, c_wreg}, 0);
      check("to_pulse", {31'b0, c_berr2}, 0);
      bus_ack_i = 1;
      step();
      bus_ack_i = 0;
      check("late_ack", {31'b0, wb_valid_o}, 0);
      mem_access(4'd8, 32'h300, 32'hCAFEF00D, 0, 4);
      check("ack4_req_n", req_n, 4);
      check("ack4_berr", {31'b0, c_berr}, 0);
      check("ack4_wbv", {31'b0, c_wbv}, 1);

      valid_i = 1; mem_op_i = 4'd5; mem_addr_i = 32'h400; wd_i = 6;
      step(); step();
      check("pre_rst_req", {31'b0, bus_req_o}, 1);
      rst = 1; valid_i = 0;
      step();
      rst = 0;
      check("mid_rst_req", {31'b0, bus_req_o}, 0);
      check("mid_rst_stall", {31'b0, stall_o}, 0);
      check("mid_rst_out", {wb_valid_o, wreg_o, wd_o, align_err_o, bus_err_o}, 0);
      check("mid_rst_wdata", wdata_o, 0);
      valid_i = 1; mem_op_i = 0; wd_i = 9; wreg_i = 1; wdata_i = 32'hABCD;
      step();
      check("post_add_wd", {27'b0, wd_o}, 9);
      check("post_add_wdata", wdata_o, 32'hABCD);
      valid_i = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
